// File: rtl/ext_mem_responder.sv
// ext_mem_responder
//
// Memory side of the multiplexed P0/P2 external bus. Latches the low address
// from P0 on ALE falling, serves opcode fetches from a code ROM (PSEN low),
// XDATA reads (RD low) and XDATA writes (WR low, committed on WR rise).
// The code ROM can be preloaded through the prog_* port.
//
// Ports:
//   clk        system clock, shared with the control unit
//   reset      synchronous, active-high
//   ALE        address latch enable, active high
//   PSEN       program strobe, active low
//   RD         XDATA read strobe, active low
//   WR         XDATA write strobe, active low
//   P0_in      P0 bus in (address low / write data)
//   P2_in      P2 bus in (address high)
//   P0_out     read data driven onto P0
//   P0_oe      P0 drive enable
//   prog_we    code ROM preload write enable
//   prog_addr  code ROM preload address
//   prog_data  code ROM preload data
//   bus_err    sticky flag: more than one strobe low at the same edge

module ext_mem_responder #(
    parameter int unsigned CODE_AW  = 12,
    parameter int unsigned XDATA_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ALE,
    input  logic               PSEN,
    input  logic               RD,
    input  logic               WR,
    input  logic [7:0]         P0_in,
    input  logic [7:0]         P2_in,
    output logic [7:0]         P0_out,
    output logic               P0_oe,
    input  logic               prog_we,
    input  logic [CODE_AW-1:0] prog_addr,
    input  logic [7:0]         prog_data,
    output logic               bus_err
);

    typedef enum logic [1:0] {
        StIdle,
        StCodeRd,
        StXdataRd,
        StXdataWr
    } state_e;

    // Registered copies of the bus inputs, used for edge detection.
    logic       r_ale_q;
    logic       r_psen_q;
    logic       r_rd_q;
    logic       r_wr_q;
    logic [7:0] r_p0_q;
    logic [7:0] r_p2_q;

    logic [7:0] r_addr_lo;
    logic [7:0] r_addr_hi;

    state_e     r_state;
    logic [7:0] r_p0_out;
    logic       r_p0_oe;
    logic       r_bus_err;
    // Strobes are ignored until all three are sampled high; set by reset and
    // by a multi-strobe collision so a strobe already low never starts a cycle.
    logic       r_hold;

    logic [7:0] r_code_mem  [2**CODE_AW];
    logic [7:0] r_xdata_mem [2**XDATA_AW];

    state_e              w_state_next;
    logic [7:0]          w_p0_out_next;
    logic                w_p0_oe_next;
    logic                w_bus_err_next;
    logic                w_hold_next;
    logic                w_xdata_we;
    logic [CODE_AW-1:0]  w_code_addr;
    logic [XDATA_AW-1:0] w_xaddr;
    logic                w_multi;
    logic                w_all_high;
    logic                w_psen_fall;
    logic                w_rd_fall;
    logic                w_wr_fall;
    logic                w_wr_rise;

    assign w_code_addr = CODE_AW'({r_addr_hi, r_addr_lo});
    assign w_xaddr     = XDATA_AW'({r_addr_hi, r_addr_lo});

    assign w_multi     = (~PSEN & ~RD) | (~PSEN & ~WR) | (~RD & ~WR);
    assign w_all_high  = PSEN & RD & WR;
    assign w_psen_fall = ~PSEN & r_psen_q;
    assign w_rd_fall   = ~RD & r_rd_q;
    assign w_wr_fall   = ~WR & r_wr_q;
    assign w_wr_rise   = WR & ~r_wr_q;

    always_comb begin
        w_state_next   = r_state;
        w_p0_out_next  = r_p0_out;
        w_p0_oe_next   = r_p0_oe;
        w_bus_err_next = r_bus_err;
        w_hold_next    = r_hold;
        w_xdata_we     = 1'b0;

        if (w_multi) begin
            w_bus_err_next = 1'b1;
            w_hold_next    = 1'b1;
        end else if (w_all_high) begin
            w_hold_next = 1'b0;
        end

        if (ALE || w_multi) begin
            // ALE high means the control unit drives P0: release and abort.
            w_state_next = StIdle;
            w_p0_oe_next = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!r_hold) begin
                        if (w_psen_fall) begin
                            w_state_next  = StCodeRd;
                            w_p0_out_next = r_code_mem[w_code_addr];
                            w_p0_oe_next  = 1'b1;
                        end else if (w_rd_fall) begin
                            w_state_next  = StXdataRd;
                            w_p0_out_next = r_xdata_mem[w_xaddr];
                            w_p0_oe_next  = 1'b1;
                        end else if (w_wr_fall) begin
                            w_state_next = StXdataWr;
                        end
                    end
                end
                StCodeRd: begin
                    if (PSEN) begin
                        w_state_next = StIdle;
                        w_p0_oe_next = 1'b0;
                    end
                end
                StXdataRd: begin
                    if (RD) begin
                        w_state_next = StIdle;
                        w_p0_oe_next = 1'b0;
                    end
                end
                StXdataWr: begin
                    if (w_wr_rise) begin
                        w_state_next = StIdle;
                        w_xdata_we   = 1'b1;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                    w_p0_oe_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ale_q   <= 1'b0;
            r_psen_q  <= 1'b1;
            r_rd_q    <= 1'b1;
            r_wr_q    <= 1'b1;
            r_p0_q    <= 8'h00;
            r_p2_q    <= 8'h00;
            r_addr_lo <= 8'h00;
            r_addr_hi <= 8'h00;
            r_state   <= StIdle;
            r_p0_out  <= 8'h00;
            r_p0_oe   <= 1'b0;
            r_bus_err <= 1'b0;
            r_hold    <= 1'b1;
        end else begin
            r_ale_q  <= ALE;
            r_psen_q <= PSEN;
            r_rd_q   <= RD;
            r_wr_q   <= WR;
            r_p0_q   <= P0_in;
            r_p2_q   <= P2_in;
            // Take the address that was on the bus while ALE was still high.
            if (!ALE && r_ale_q) begin
                r_addr_lo <= r_p0_q;
                r_addr_hi <= r_p2_q;
            end
            r_state   <= w_state_next;
            r_p0_out  <= w_p0_out_next;
            r_p0_oe   <= w_p0_oe_next;
            r_bus_err <= w_bus_err_next;
            r_hold    <= w_hold_next;
        end
    end

    // Memories are deliberately not reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_code_mem[prog_addr] <= prog_data;
        end
        if (w_xdata_we) begin
            // Data sampled at the edge before the rise, while WR was still low.
            r_xdata_mem[w_xaddr] <= r_p0_q;
        end
    end

    assign P0_out  = r_p0_out;
    assign P0_oe   = r_p0_oe;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_ext_mem_responder.sv
module tb_ext_mem_responder;

    localparam int unsigned CODE_AW  = 12;
    localparam int unsigned XDATA_AW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               ALE;
    logic               PSEN;
    logic               RD;
    logic               WR;
    logic [7:0]         P0_in;
    logic [7:0]         P2_in;
    logic [7:0]         P0_out;
    logic               P0_oe;
    logic               prog_we;
    logic [CODE_AW-1:0] prog_addr;
    logic [7:0]         prog_data;
    logic               bus_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain byte arrays updated per completed bus transaction.
    logic [7:0] code_m  [2**CODE_AW];
    logic [7:0] xdata_m [2**XDATA_AW];

    ext_mem_responder #(
        .CODE_AW  (CODE_AW),
        .XDATA_AW (XDATA_AW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .ALE       (ALE),
        .PSEN      (PSEN),
        .RD        (RD),
        .WR        (WR),
        .P0_in     (P0_in),
        .P2_in     (P2_in),
        .P0_out    (P0_out),
        .P0_oe     (P0_oe),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [CODE_AW-1:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
        code_m[a] = d;
    endtask

    task automatic addr_phase(input logic [15:0] a);
        ALE   = 1'b1;
        P2_in = a[15:8];
        P0_in = a[7:0];
        step();
        ALE = 1'b0;
        step();
        P0_in = 8'($urandom);
    endtask

    // Fetch (is_code) or XDATA read of a; checks drive during and after strobe.
    task automatic read_cycle(input bit is_code, input logic [15:0] a, input bit do_addr,
                              input string tag);
        logic [7:0] exp;
        exp = is_code ? code_m[a[CODE_AW-1:0]] : xdata_m[a[XDATA_AW-1:0]];
        if (do_addr) addr_phase(a);
        if (is_code) PSEN = 1'b0; else RD = 1'b0;
        step();
        check({tag, " oe"}, 16'(P0_oe), 16'd1);
        check({tag, " data"}, 16'(P0_out), 16'(exp));
        step();
        check({tag, " data2"}, 16'(P0_out), 16'(exp));
        step();
        PSEN = 1'b1;
        RD   = 1'b1;
        step();
        check({tag, " release"}, 16'(P0_oe), 16'd0);
    endtask

    task automatic write_cycle(input logic [15:0] a, input logic [7:0] d, input bit abort);
        addr_phase(a);
        P0_in = d;
        WR    = 1'b0;
        step();
        step();
        if (abort) begin
            ALE = 1'b1;
            step();
            WR = 1'b1;
            step();
            ALE = 1'b0;
            step();
        end else begin
            WR = 1'b1;
            step();
            xdata_m[a[XDATA_AW-1:0]] = d;
            P0_in = 8'($urandom);
        end
        check("write no drive", 16'(P0_oe), 16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        ALE       = 1'b0;
        PSEN      = 1'b1;
        RD        = 1'b1;
        WR        = 1'b1;
        P0_in     = 8'h00;
        P2_in     = 8'h00;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = 8'h00;
        step();
        step();
        check("reset oe", 16'(P0_oe), 16'd0);
        check("reset out", 16'(P0_out), 16'd0);
        check("reset err", 16'(bus_err), 16'd0);
        reset = 1'b0;
        step();

        // Fill both memories so every random read has a known expected value.
        for (int i = 0; i < 2**CODE_AW; i++) preload(CODE_AW'(i), 8'($urandom));
        for (int i = 0; i < 2**XDATA_AW; i++)
            write_cycle({8'($urandom), 8'(i)}, 8'($urandom), 1'b0);

        // Directed: fetch of preloaded byte.
        preload(12'h123, 8'hA5);
        read_cycle(1'b1, 16'h0123, 1'b1, "fetch 123");
        check("fetch 123 value", 16'(P0_out), 16'h00A5);

        // Write then read back, neighbour untouched.
        write_cycle(16'h0041, 8'h3C, 1'b0);
        write_cycle(16'h0040, 8'h5A, 1'b0);
        read_cycle(1'b0, 16'h0040, 1'b1, "rd 40");
        check("rd 40 value", 16'(P0_out), 16'h005A);
        read_cycle(1'b0, 16'h0041, 1'b1, "rd 41");

        // Write aborted by ALE must not commit.
        write_cycle(16'h0040, 8'h77, 1'b1);
        read_cycle(1'b0, 16'h0040, 1'b1, "rd 40 after abort");
        check("abort keeps old", 16'(P0_out), 16'h005A);

        // Two strobes at once: sticky error, no drive.
        addr_phase(16'h0123);
        PSEN = 1'b0;
        RD   = 1'b0;
        step();
        check("collide err", 16'(bus_err), 16'd1);
        check("collide oe", 16'(P0_oe), 16'd0);
        step();
        check("collide oe2", 16'(P0_oe), 16'd0);
        PSEN = 1'b1;
        RD   = 1'b1;
        step();
        read_cycle(1'b1, 16'h0123, 1'b1, "fetch after err");
        check("err sticky", 16'(bus_err), 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("err cleared", 16'(bus_err), 16'd0);

        // Reset mid-fetch; PSEN still low at release must not fetch.
        preload(12'h000, 8'hC3);
        addr_phase(16'h0123);
        PSEN = 1'b0;
        step();
        check("pre-reset oe", 16'(P0_oe), 16'd1);
        reset = 1'b1;
        step();
        check("mid reset oe", 16'(P0_oe), 16'd0);
        check("mid reset out", 16'(P0_out), 16'd0);
        reset = 1'b0;
        step();
        step();
        check("stale psen no fetch", 16'(P0_oe), 16'd0);
        PSEN = 1'b1;
        step();
        read_cycle(1'b1, 16'h0000, 1'b0, "fresh fetch addr0");
        check("addr reset to 0", 16'(P0_out), 16'h00C3);

        // Back-to-back fetches with the byte rewritten during the first.
        preload(12'h2B4, 8'h11);
        addr_phase(16'h02B4);
        PSEN = 1'b0;
        step();
        check("b2b first", 16'(P0_out), 16'h0011);
        prog_we   = 1'b1;
        prog_addr = 12'h2B4;
        prog_data = 8'h22;
        step();
        prog_we = 1'b0;
        code_m[12'h2B4] = 8'h22;
        check("b2b first held", 16'(P0_out), 16'h0011);
        PSEN = 1'b1;
        step();
        read_cycle(1'b1, 16'h02B4, 1'b0, "b2b second");
        check("b2b second value", 16'(P0_out), 16'h0022);

        // Random transactions against the array model.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: read_cycle(1'b1, a, 1'b1, "rand fetch");
                1: read_cycle(1'b0, a, 1'b1, "rand read");
                2: write_cycle(a, 8'($urandom), 1'b0);
                default: write_cycle(a, 8'($urandom), 1'b1);
            endcase
        end
        check("final err", 16'(bus_err), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
